// File: rtl/byte_bus_arbiter_pkg.sv
// Shared types and constants for the round-robin byte bus arbiter.
// The arbiter FSM walks IDLE -> GRANT -> SEND -> RELEASE for every burst.
package byte_bus_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    RELEASE
  } arb_state_t;

  // Rotating priority: the slot after the last owner becomes the new favourite.
  function automatic int wrapInc(input int value, input int modulus);
    return (value + 1) % modulus;
  endfunction

endpackage

// File: rtl/byte_bus_arbiter_if.sv
// Bundle of producer-side requests/bytes and consumer-side handshake of the byte link.
// master = environment (producers + consumer), slave = the arbiter itself.
interface byte_bus_arbiter_if #(
  parameter int N_REQ = 4
);
  import byte_bus_arbiter_pkg::*;

  logic [N_REQ-1:0]        reqIn;
  logic [BYTE_W*N_REQ-1:0] dataIn;
  logic [N_REQ-1:0]        grantOut;
  logic [N_REQ-1:0]        takenOut;
  logic                    readyOut;
  logic [BYTE_W-1:0]       sharedBusOut;
  logic                    acceptedIn;
  logic                    busErr;

  modport master (
    output reqIn, dataIn, acceptedIn,
    input  grantOut, takenOut, readyOut, sharedBusOut, busErr
  );

  modport slave (
    input  reqIn, dataIn, acceptedIn,
    output grantOut, takenOut, readyOut, sharedBusOut, busErr
  );

endinterface

// File: rtl/byte_bus_arbiter_picker.sv
// Round-robin picker: first requester at or after ptr, wrapping past the top index.
// Purely combinational; the arbiter registers the result when it leaves IDLE.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [PTR_W-1:0] winnerIdx,
  output logic             valid
);

  always_comb begin
    int idx;
    logic found;
    winner    = '0;
    winnerIdx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        winnerIdx   = PTR_W'(idx);
        found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/byte_bus_arbiter.sv
// Round-robin arbiter sharing one ready/accepted byte link among N_REQ producers,
// granting fixed-length bursts with a consumer-stall timeout.
module byte_bus_arbiter
  import byte_bus_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input logic              clkArb,
  input logic              reset,
  byte_bus_arbiter_if.slave bus
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state, stateNext;
  logic [N_REQ-1:0]  grantReg, grantNext;
  logic [PTR_W-1:0]  grantIdx, grantIdxNext;
  logic [PTR_W-1:0]  ptr, ptrNext;
  logic              readyReg, readyNext;
  logic              busErrReg, busErrNext;
  logic [CNT_W-1:0]  byteCnt, byteCntNext;
  logic [WAIT_W-1:0] waitCnt, waitCntNext;

  logic [N_REQ-1:0]  pickOneHot;
  logic [PTR_W-1:0]  pickIdx;
  logic              pickValid;
  logic              accept;
  logic              ownerReq;
  logic              leaveSend;
  logic [BYTE_W-1:0] busMux;

  rr_priority_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) picker (
    .req       (bus.reqIn),
    .ptr       (ptr),
    .winner    (pickOneHot),
    .winnerIdx (pickIdx),
    .valid     (pickValid)
  );

  // readyReg is only ever high in SEND, so it alone qualifies the handshake.
  assign accept   = readyReg & bus.acceptedIn;
  assign ownerReq = |(bus.reqIn & grantReg);

  always_comb begin
    stateNext    = state;
    grantNext    = grantReg;
    grantIdxNext = grantIdx;
    readyNext    = readyReg;
    busErrNext   = 1'b0;
    ptrNext      = ptr;
    byteCntNext  = byteCnt;
    waitCntNext  = waitCnt;
    leaveSend    = 1'b0;
    case (state)
      IDLE: begin
        if (pickValid) begin
          grantNext    = pickOneHot;
          grantIdxNext = pickIdx;
          stateNext    = GRANT;
        end
      end
      GRANT: begin
        readyNext = 1'b1;
        stateNext = SEND;
      end
      SEND: begin
        if (accept) begin
          byteCntNext = byteCnt + 1'b1;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
        // A dropped request wins over a coincident timeout, so it never flags busErr.
        if (!ownerReq || (accept && byteCnt == CNT_W'(BURST_LEN - 1))) begin
          leaveSend = 1'b1;
        end else if (!accept && waitCnt == WAIT_W'(TIMEOUT - 1)) begin
          leaveSend  = 1'b1;
          busErrNext = 1'b1;
        end
        if (leaveSend) begin
          grantNext = '0;
          readyNext = 1'b0;
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        grantNext   = '0;
        readyNext   = 1'b0;
        byteCntNext = '0;
        waitCntNext = '0;
        ptrNext     = PTR_W'(wrapInc(int'(grantIdx), N_REQ));
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkArb or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grantReg  <= '0;
      grantIdx  <= '0;
      readyReg  <= 1'b0;
      busErrReg <= 1'b0;
      ptr       <= '0;
      byteCnt   <= '0;
      waitCnt   <= '0;
    end else begin
      state     <= stateNext;
      grantReg  <= grantNext;
      grantIdx  <= grantIdxNext;
      readyReg  <= readyNext;
      busErrReg <= busErrNext;
      ptr       <= ptrNext;
      byteCnt   <= byteCntNext;
      waitCnt   <= waitCntNext;
    end
  end

  always_comb begin
    busMux = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantReg[i]) busMux = busMux | bus.dataIn[i*BYTE_W +: BYTE_W];
    end
  end

  assign bus.grantOut     = grantReg;
  assign bus.readyOut     = readyReg;
  assign bus.busErr       = busErrReg;
  assign bus.takenOut     = accept ? grantReg : '0;
  assign bus.sharedBusOut = busMux;

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// Directed bench for byte_bus_arbiter: expected bytes are queued per burst and
// matched against every consumer handshake seen on the link.
module tb_byte_bus_arbiter;

  localparam int N_REQ = 4;

  typedef struct {
    int         req;
    logic [7:0] data;
  } sbEntry_t;

  logic clkArb = 1'b0;
  logic reset;

  always #5 clkArb = ~clkArb;

  byte_bus_arbiter_if #(.N_REQ(N_REQ)) bif ();

  byte_bus_arbiter #(.N_REQ(N_REQ), .BURST_LEN(8), .TIMEOUT(64)) dut (
    .clkArb (clkArb),
    .reset  (reset),
    .bus    (bif)
  );

  sbEntry_t sb[$];
  int total = 0;
  int bad   = 0;
  int idx[N_REQ];
  int takenCnt[N_REQ];
  int hsCnt;
  int cnt;
  int gap;

  logic [N_REQ-1:0] sGrant, sTaken;
  logic             sReady, sBusErr;
  logic [7:0]       sBus;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each producer shows byte 0x80 + 0x10*i + (bytes already consumed).
  task automatic applyStimulus();
    for (int i = 0; i < N_REQ; i++) bif.dataIn[i*8 +: 8] = 8'(8'h80 + 16*i + idx[i]);
  endtask

  task automatic pushBurst(input int r, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{req: r, data: 8'(8'h80 + 16*r + k)});
  endtask

  task automatic clearModel();
    for (int i = 0; i < N_REQ; i++) begin
      idx[i]      = 0;
      takenCnt[i] = 0;
    end
    hsCnt = 0;
    applyStimulus();
  endtask

  // Observe at the falling edge, then move to just after the next rising edge.
  task automatic cycleStep();
    sbEntry_t e;
    logic acc;
    @(negedge clkArb);
    sGrant  = bif.grantOut;
    sTaken  = bif.takenOut;
    sReady  = bif.readyOut;
    sBusErr = bif.busErr;
    sBus    = bif.sharedBusOut;
    acc     = bif.acceptedIn;
    if (sReady && acc) begin
      hsCnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpectedTaken", 32'(sTaken), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("busByte", 32'(sBus), 32'(e.data));
        checkOutput("takenOneHot", 32'(sTaken), 32'd1 << e.req);
      end
    end else begin
      checkOutput("takenIdle", 32'(sTaken), 32'd0);
    end
    if (sGrant == '0) checkOutput("busIdle", 32'(sBus), 32'd0);
    for (int i = 0; i < N_REQ; i++) begin
      if (sTaken[i]) takenCnt[i]++;
      if (sReady && acc && sGrant[i]) idx[i]++;
    end
    @(posedge clkArb);
    #1;
    applyStimulus();
  endtask

  task automatic waitGrant(input logic [N_REQ-1:0] exp, input string tag);
    for (int c = 0; c < 20; c++) begin
      cycleStep();
      if (sGrant != '0) break;
    end
    checkOutput(tag, 32'(sGrant), 32'(exp));
  endtask

  task automatic waitIdle(input string tag);
    for (int c = 0; c < 100; c++) begin
      cycleStep();
      if (sGrant == '0) break;
    end
    checkOutput(tag, 32'(sGrant), 32'd0);
  endtask

  task automatic drainTo(input int n, input string tag);
    for (int c = 0; c < 200; c++) begin
      if (sb.size() <= n) break;
      cycleStep();
    end
    checkOutput(tag, 32'(sb.size()), 32'(n));
  endtask

  task automatic doReset();
    reset = 1'b0;
    cycleStep();
    cycleStep();
    reset = 1'b1;
    clearModel();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset          = 1'b0;
    bif.reqIn      = 4'b0101;
    bif.acceptedIn = 1'b1;
    clearModel();
    cycleStep();
    cycleStep();
    checkOutput("rstGrant", 32'(sGrant), 32'd0);
    checkOutput("rstReady", 32'(sReady), 32'd0);
    checkOutput("rstBusErr", 32'(sBusErr), 32'd0);
    checkOutput("rstTaken", 32'(sTaken), 32'd0);
    checkOutput("rstBus", 32'(sBus), 32'd0);

    $display("[TB] reset mid-SEND");
    bif.reqIn      = 4'b0010;
    bif.acceptedIn = 1'b0;
    reset          = 1'b1;
    waitGrant(4'b0010, "t1grantReq1");
    bif.reqIn = 4'b0000;
    waitIdle("t1abortIdle");
    bif.reqIn      = 4'b1000;
    bif.acceptedIn = 1'b1;
    pushBurst(3, 3);
    waitGrant(4'b1000, "t1grantReq3");
    drainTo(0, "t1threeBytes");
    bif.acceptedIn = 1'b0;
    @(negedge clkArb);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t1rstGrant", 32'(bif.grantOut), 32'd0);
    checkOutput("t1rstReady", 32'(bif.readyOut), 32'd0);
    checkOutput("t1rstBusErr", 32'(bif.busErr), 32'd0);
    checkOutput("t1rstBus", 32'(bif.sharedBusOut), 32'd0);
    cycleStep();
    cycleStep();
    bif.reqIn = 4'b1010;
    reset     = 1'b1;
    clearModel();
    waitGrant(4'b0010, "t1grantFromPtr0");
    bif.reqIn = 4'b0000;
    waitIdle("t1idle");

    $display("[TB] two requesters, consumer always accepts");
    doReset();
    pushBurst(0, 8);
    pushBurst(2, 8);
    bif.reqIn      = 4'b0101;
    bif.acceptedIn = 1'b1;
    waitGrant(4'b0001, "t2grantReq0");
    drainTo(8, "t2req0Bytes");
    waitIdle("t2gap");
    waitGrant(4'b0100, "t2grantReq2");
    checkOutput("t2takenReq0", 32'(takenCnt[0]), 32'd8);
    bif.reqIn = 4'b0100;
    drainTo(0, "t2req2Bytes");
    bif.reqIn      = 4'b0000;
    bif.acceptedIn = 1'b0;
    waitIdle("t2idle");
    checkOutput("t2takenReq2", 32'(takenCnt[2]), 32'd8);

    $display("[TB] all requesting, rotation and gaps");
    doReset();
    for (int r = 0; r < 4; r++) pushBurst(r, 8);
    bif.reqIn      = 4'b1111;
    bif.acceptedIn = 1'b1;
    waitGrant(4'b0001, "t3grant0");
    for (int b = 1; b <= 4; b++) begin
      drainTo(8*(4-b), "t3burstBytes");
      if (b == 4) bif.acceptedIn = 1'b0;
      gap = 0;
      for (int c = 0; c < 10; c++) begin
        cycleStep();
        if (sReady) break;
        gap++;
      end
      checkOutput("t3gapCycles", 32'(gap), 32'd3);
      checkOutput("t3grantOrder", 32'(sGrant), 32'd1 << (b % 4));
    end
    bif.reqIn = 4'b0000;
    waitIdle("t3idle");

    $display("[TB] consumer stall timeout");
    bif.reqIn      = 4'b0010;
    bif.acceptedIn = 1'b0;
    waitGrant(4'b0010, "t4grantReq1");
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      cycleStep();
      if (!sReady) break;
      cnt++;
    end
    checkOutput("t4sendCycles", 32'(cnt), 32'd64);
    checkOutput("t4busErr", 32'(sBusErr), 32'd1);
    checkOutput("t4grantCleared", 32'(sGrant), 32'd0);
    bif.reqIn = 4'b0110;
    cycleStep();
    checkOutput("t4busErrOnce", 32'(sBusErr), 32'd0);
    waitGrant(4'b0100, "t4nextReq2");
    bif.reqIn = 4'b0000;
    waitIdle("t4idle");

    $display("[TB] requester drop during SEND");
    clearModel();
    pushBurst(3, 5);
    bif.reqIn      = 4'b1000;
    bif.acceptedIn = 1'b1;
    waitGrant(4'b1000, "t5grantReq3");
    drainTo(0, "t5fiveBytes");
    bif.reqIn      = 4'b0000;
    bif.acceptedIn = 1'b0;
    cycleStep();
    cycleStep();
    checkOutput("t5dropGrant", 32'(sGrant), 32'd0);
    checkOutput("t5dropBusErr", 32'(sBusErr), 32'd0);
    bif.reqIn = 4'b1001;
    waitGrant(4'b0001, "t5ptrWrapped");
    bif.reqIn = 4'b0000;
    waitIdle("t5abortIdle");
    idx[3] = 0;
    applyStimulus();
    pushBurst(3, 8);
    bif.reqIn      = 4'b1000;
    bif.acceptedIn = 1'b1;
    waitGrant(4'b1000, "t5grantReq3Again");
    drainTo(1, "t5sevenBytes");
    bif.reqIn = 4'b0000;
    cycleStep();
    bif.acceptedIn = 1'b0;
    cycleStep();
    checkOutput("t5lastBusErr", 32'(sBusErr), 32'd0);
    checkOutput("t5lastGrant", 32'(sGrant), 32'd0);
    checkOutput("t5takenReq3", 32'(takenCnt[3]), 32'd13);

    $display("[TB] toggling acceptedIn");
    clearModel();
    pushBurst(0, 8);
    bif.reqIn      = 4'b0001;
    bif.acceptedIn = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0) break;
      cycleStep();
      bif.acceptedIn = ~bif.acceptedIn;
    end
    checkOutput("t6allBytes", 32'(sb.size()), 32'd0);
    bif.reqIn      = 4'b0000;
    bif.acceptedIn = 1'b0;
    waitIdle("t6idle");
    checkOutput("t6pulsesVsHandshakes", 32'(takenCnt[0]), 32'(hsCnt));
    checkOutput("t6pulseCount", 32'(takenCnt[0]), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
